// File: rtl/somador_serial_param.sv
// rtl/somador_serial_param.sv - digit-serial WIDTH-bit adder/subtractor with start/busy/done handshake
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("somador_serial_param: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             accept;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx, dsum_w;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;

    // One DIGIT-wide ripple slice, reused every RUN cycle; c[DIGIT-1] is the carry into the MSB on the last digit
    always_comb begin
        c      = '0;
        dsum   = '0;
        c[0]   = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ c[i];
            c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
        end
        dsum_w             = '0;
        dsum_w[DIGIT-1:0]  = dsum;
        r_nx               = (r_sh >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Published results change only on the last digit, so s and flags are never seen half-updated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            r_sh  <= r_nx;
            carry <= c[DIGIT];
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                s    <= r_nx;
                cout <= c[DIGIT];
                ovf  <= c[DIGIT] ^ c[DIGIT-1];
                zero <= (r_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_somador_serial_param.sv
// tb/tb_somador_serial_param.sv - randomized self-checking bench for somador_serial_param (DIGIT=1 and DIGIT=4)
module tb_somador_serial_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = 2'b00;
    logic       sub_i = 1'b0;
    logic [7:0] a_i = 8'h00;
    logic [7:0] b_i = 8'h00;
    logic       busy_o [2];
    logic       done_o [2];
    logic       cout_o [2];
    logic       ovf_o  [2];
    logic       zero_o [2];
    logic [7:0] s_o    [2];
    logic [7:0] held_s [2];

    int n_checks = 0;
    int n_pass   = 0;

    somador_serial_param #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub_i), .a(a_i), .b(b_i),
        .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    somador_serial_param #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub_i), .a(a_i), .b(b_i),
        .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ndig(input int w);
        return (w == 0) ? 8 : 2;
    endfunction

    // Drive one start pulse so it is sampled on the next rising edge, then scramble the inputs
    task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input logic sb);
        a_i      = a;
        b_i      = b;
        sub_i    = sb;
        start[w] = 1'b1;
        @(posedge clk);
        #1;
        start[w] = 1'b0;
        a_i      = 8'($urandom);
        b_i      = 8'($urandom);
        sub_i    = 1'($urandom);
    endtask

    // Wait for done, checking busy/hold on the way and the arithmetic result against an integer model
    task automatic finish_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sb,
                             input int inject_at);
        int ua, ub, sa, sbv, r, lat;
        logic [7:0] e_s;
        logic e_c, e_v;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            e_s = 8'((ua - ub) & 255);
            e_c = (ua >= ub);
            r   = sa - sbv;
        end else begin
            e_s = 8'((ua + ub) & 255);
            e_c = (ua + ub) > 255;
            r   = sa + sbv;
        end
        e_v = (r > 127) || (r < -128);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                start[w] = 1'b1;
                a_i      = 8'hAA;
                b_i      = 8'h55;
            end else begin
                start[w] = 1'b0;
            end
            if (done_o[w] || lat > 20) break;
            check("busy_run", busy_o[w], 1'b1);
            check("s_hold", s_o[w], held_s[w]);
        end
        start[w] = 1'b0;
        check("latency", lat, ndig(w) + 1);
        check("done", done_o[w], 1'b1);
        check("busy_done", busy_o[w], 1'b0);
        check("s", s_o[w], e_s);
        check("cout", cout_o[w], e_c);
        check("ovf", ovf_o[w], e_v);
        check("zero", zero_o[w], (e_s == 8'h00));
        held_s[w] = e_s;
    endtask

    task automatic idle_after(input int w);
        @(negedge clk);
        check("done_drop", done_o[w], 1'b0);
        check("busy_idle", busy_o[w], 1'b0);
        check("s_idle_hold", s_o[w], held_s[w]);
    endtask

    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic sb);
        issue(w, a, b, sb);
        finish_op(w, a, b, sb, 0);
        idle_after(w);
    endtask

    initial begin
        int w, n_done;
        logic [7:0] ra, rb;
        logic rs;
        held_s[0] = 8'h00;
        held_s[1] = 8'h00;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", busy_o[i], 1'b0);
            check("rst_done", done_o[i], 1'b0);
            check("rst_s", s_o[i], 8'h00);
            check("rst_flags", {cout_o[i], ovf_o[i], zero_o[i]}, 3'b000);
        end
        rst_n = 1'b1;

        op(0, 8'h7F, 8'h01, 1'b0);
        op(0, 8'hFF, 8'h01, 1'b0);
        op(0, 8'h05, 8'h07, 1'b1);
        op(1, 8'h80, 8'h01, 1'b1);

        // start during RUN must be ignored; then back-to-back start in the DONE cycle
        issue(0, 8'h10, 8'h20, 1'b0);
        finish_op(0, 8'h10, 8'h20, 1'b0, 3);
        issue(0, 8'h01, 8'h02, 1'b0);
        finish_op(0, 8'h01, 8'h02, 1'b0, 0);
        idle_after(0);

        // asynchronous reset mid-RUN
        issue(0, 8'h9A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_o[0], 1'b0);
        check("arst_done", done_o[0], 1'b0);
        check("arst_s", s_o[0], 8'h00);
        check("arst_flags", {cout_o[0], ovf_o[0], zero_o[0]}, 3'b000);
        held_s[0] = 8'h00;
        held_s[1] = 8'h00;
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0]) n_done++;
        end
        check("arst_no_done", n_done, 0);
        op(0, 8'h03, 8'h04, 1'b0);

        op(1, 8'h5A, 8'h00, 1'b1);
        op(0, 8'hC3, 8'hC3, 1'b1);
        op(1, 8'h7F, 8'h7F, 1'b0);

        for (int k = 0; k < 60; k++) begin
            w  = int'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? ra : 8'($urandom);
            rs = 1'($urandom);
            issue(w, ra, rb, rs);
            finish_op(w, ra, rb, rs, 0);
            if ($urandom_range(0, 1) == 1) idle_after(w);
        end
        start = 2'b00;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
